// File: rtl/mem_datos_if.sv
// mem_datos_if -- request/response bundle between the control unit and the
// data memory.
//   LeerMem, EscrMem : read / write requests (master -> slave)
//   Direccion        : 32-bit byte address from the ALU result
//   DatoEscr         : write data
//   DatoLeido        : registered read data (slave -> master)
//   Valido           : DatoLeido carries data for a read accepted last cycle
//   ErrorAcc         : last cycle's request was rejected
//   Ocupado          : memory clear sequence in progress, requests ignored
//   ContLect/ContEscr/ContErr : saturating 16-bit event counters
interface mem_datos_if #(
  parameter int ANCHO = 32
);
  logic             LeerMem;
  logic             EscrMem;
  logic [31:0]      Direccion;
  logic [ANCHO-1:0] DatoEscr;
  logic [ANCHO-1:0] DatoLeido;
  logic             Valido;
  logic             ErrorAcc;
  logic             Ocupado;
  logic [15:0]      ContLect;
  logic [15:0]      ContEscr;
  logic [15:0]      ContErr;

  modport master (
    output LeerMem, EscrMem, Direccion, DatoEscr,
    input  DatoLeido, Valido, ErrorAcc, Ocupado, ContLect, ContEscr, ContErr
  );

  modport slave (
    input  LeerMem, EscrMem, Direccion, DatoEscr,
    output DatoLeido, Valido, ErrorAcc, Ocupado, ContLect, ContEscr, ContErr
  );
endinterface

// File: rtl/mem_datos.sv
// mem_datos -- word-addressed data memory with a post-reset clear sequence,
// request validation and saturating access counters.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; restarts the clear sequence
//   bus   : mem_datos_if slave modport (requests in, read data/status out)
// After reset the FSM sits in LIMPIAR for exactly PROF cycles writing zero to
// one word per cycle, then enters LISTO where requests are served. Reads have
// one cycle of latency through the registered read port.
module mem_datos #(
  parameter int PROF  = 64,
  parameter int ANCHO = 32
) (
  input  logic         clk,
  input  logic         reset,
  mem_datos_if.slave   bus
);

  localparam int AW = $clog2(PROF);

  typedef enum logic {LIMPIAR, LISTO} estado_t;

  estado_t       estado_q, estado_d;
  logic [AW-1:0] idx_q, idx_d;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= LIMPIAR;
      idx_q    <= '0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    idx_d    = idx_q;
    if (estado_q == LIMPIAR) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == AW'(PROF - 1)) begin
        estado_d = LISTO;
      end
    end
  end

  // ------------------------------------------------------ request decode
  logic          listo;
  logic          conflicto, desalineado, fuera_rango, invalida;
  logic          lect_ok, escr_ok, rechazo;
  logic [AW-1:0] palabra;

  assign listo       = (estado_q == LISTO);
  assign conflicto   = bus.LeerMem & bus.EscrMem;
  assign desalineado = |bus.Direccion[1:0];
  // Any bit at or above byte 4*PROF puts the address out of range.
  assign fuera_rango = |bus.Direccion[31:AW+2];
  assign invalida    = conflicto | desalineado | fuera_rango;
  assign palabra     = bus.Direccion[AW+1:2];

  assign lect_ok = listo & bus.LeerMem & ~invalida;
  assign escr_ok = listo & bus.EscrMem & ~invalida;
  assign rechazo = listo & (bus.LeerMem | bus.EscrMem) & invalida;

  // -------------------------------------------------------------- memory
  // Single write port shared by the clear walker and accepted writes; the
  // two never overlap because writes are only accepted in LISTO.
  logic [ANCHO-1:0] mem [PROF];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [ANCHO-1:0] mem_wdata;

  assign mem_we    = ~reset & (~listo | escr_ok);
  assign mem_waddr = listo ? palabra : idx_q;
  assign mem_wdata = listo ? bus.DatoEscr : '0;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read port; holds its value unless a read is accepted.
  logic [ANCHO-1:0] dato_q;
  logic             valido_q;
  logic             error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dato_q   <= '0;
      valido_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      valido_q <= lect_ok;
      error_q  <= rechazo;
      if (lect_ok) begin
        dato_q <= mem[palabra];
      end
    end
  end

  // ------------------------------------------------------------ counters
  // Index 0: accepted reads, 1: accepted writes, 2: rejected requests.
  logic [2:0]  cnt_inc;
  logic [15:0] cnt_q [3];
  logic [15:0] cnt_d [3];

  assign cnt_inc = {rechazo, escr_ok, lect_ok};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    always_comb begin
      cnt_d[gi] = cnt_q[gi];
      if (cnt_inc[gi] && (cnt_q[gi] != 16'hFFFF)) begin
        cnt_d[gi] = cnt_q[gi] + 16'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q[gi] <= '0;
      end else begin
        cnt_q[gi] <= cnt_d[gi];
      end
    end
  end

  // ------------------------------------------------------------- outputs
  assign bus.DatoLeido = dato_q;
  assign bus.Valido    = valido_q;
  assign bus.ErrorAcc  = error_q;
  assign bus.Ocupado   = (estado_q == LIMPIAR);
  assign bus.ContLect  = cnt_q[0];
  assign bus.ContEscr  = cnt_q[1];
  assign bus.ContErr   = cnt_q[2];

endmodule

// File: tb/tb_mem_datos.sv
// tb_mem_datos -- directed self-checking bench for mem_datos (PROF=64,
// ANCHO=32). Inputs change 1 ns after each rising edge and outputs are
// sampled at the same point, so every check sees the state left by the edge.
module tb_mem_datos;

  logic clk;
  logic reset;

  mem_datos_if #(.ANCHO(32)) bus ();

  mem_datos #(.PROF(64), .ANCHO(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data);
    bus.LeerMem   = rd;
    bus.EscrMem   = wr;
    bus.Direccion = addr;
    bus.DatoEscr  = data;
  endtask

  // Counts cycles with Ocupado high, bounded so a stuck FSM still ends.
  task automatic wait_clear(output int n);
    n = 0;
    while (bus.Ocupado === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  int n_busy;
  int bad_valid;
  int saw_err;

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    // ---- reset state and clear length
    tick();
    chk("rst_dato",   bus.DatoLeido, 32'h0);
    chk("rst_valido", 32'(bus.Valido), 32'h0);
    chk("rst_error",  32'(bus.ErrorAcc), 32'h0);
    chk("rst_ocup",   32'(bus.Ocupado), 32'h1);
    chk("rst_clect",  32'(bus.ContLect), 32'h0);
    chk("rst_cescr",  32'(bus.ContEscr), 32'h0);
    chk("rst_cerr",   32'(bus.ContErr), 32'h0);
    reset = 1'b0;
    wait_clear(n_busy);
    chk("clear_len", 32'(n_busy), 32'd64);

    // ---- back-to-back reads of a cleared memory, incl. top word
    drive(1'b1, 1'b0, 32'h00, 32'h0); tick();
    chk("rd00_val", 32'(bus.Valido), 32'h1);
    chk("rd00_dat", bus.DatoLeido, 32'h0);
    drive(1'b1, 1'b0, 32'h7C, 32'h0); tick();
    chk("rd7c_val", 32'(bus.Valido), 32'h1);
    chk("rd7c_dat", bus.DatoLeido, 32'h0);
    drive(1'b1, 1'b0, 32'hFC, 32'h0); tick();
    chk("rdfc_val", 32'(bus.Valido), 32'h1);
    chk("rdfc_dat", bus.DatoLeido, 32'h0);

    // ---- write then read next cycle
    drive(1'b0, 1'b1, 32'h10, 32'hDEADBEEF); tick();
    chk("wr_val", 32'(bus.Valido), 32'h0);
    chk("wr_dat_hold", bus.DatoLeido, 32'h0);
    drive(1'b1, 1'b0, 32'h10, 32'h0); tick();
    chk("raw_val", 32'(bus.Valido), 32'h1);
    chk("raw_dat", bus.DatoLeido, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 32'h10, 32'h0); tick();
    chk("idle_val", 32'(bus.Valido), 32'h0);
    chk("idle_hold", bus.DatoLeido, 32'hDEADBEEF);
    chk("cnt_lect4", 32'(bus.ContLect), 32'd4);
    chk("cnt_escr1", 32'(bus.ContEscr), 32'd1);

    // ---- rejections
    drive(1'b1, 1'b0, 32'h12, 32'h0); tick();
    chk("rej_misal_err", 32'(bus.ErrorAcc), 32'h1);
    chk("rej_misal_val", 32'(bus.Valido), 32'h0);
    drive(1'b0, 1'b1, 32'h100, 32'h0000CAFE); tick();
    chk("rej_range_err", 32'(bus.ErrorAcc), 32'h1);
    drive(1'b1, 1'b1, 32'h0, 32'h12345678); tick();
    chk("rej_both_err", 32'(bus.ErrorAcc), 32'h1);
    chk("rej_both_val", 32'(bus.Valido), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0); tick();
    chk("rej_pulse_end", 32'(bus.ErrorAcc), 32'h0);
    chk("cnt_err3", 32'(bus.ContErr), 32'd3);
    chk("cnt_escr_rej", 32'(bus.ContEscr), 32'd1);
    chk("cnt_lect_rej", 32'(bus.ContLect), 32'd4);
    chk("rej_dat_hold", bus.DatoLeido, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 32'h0, 32'h0); tick();
    chk("rej_mem0", bus.DatoLeido, 32'h0);
    drive(1'b1, 1'b0, 32'h10, 32'h0); tick();
    chk("rej_mem10", bus.DatoLeido, 32'hDEADBEEF);

    // ---- requests during clear are ignored (incl. one sampled with reset)
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'h8, 32'h00001234);
    tick();
    reset = 1'b0;
    saw_err = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.ErrorAcc !== 1'b0) saw_err++;
    end
    chk("busy_err", 32'(saw_err), 32'd0);
    chk("busy_cescr", 32'(bus.ContEscr), 32'd0);
    chk("busy_cerr", 32'(bus.ContErr), 32'd0);
    chk("busy_ocup", 32'(bus.Ocupado), 32'h1);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    wait_clear(n_busy);
    chk("busy_done", 32'(bus.Ocupado), 32'h0);
    drive(1'b1, 1'b0, 32'h8, 32'h0); tick();
    chk("busy_rd8", bus.DatoLeido, 32'h0);
    chk("busy_rd8_val", 32'(bus.Valido), 32'h1);
    drive(1'b1, 1'b0, 32'h10, 32'h0); tick();
    chk("reclr_rd10", bus.DatoLeido, 32'h0);

    // ---- reset mid-clear restarts from index 0
    drive(1'b0, 1'b1, 32'h4, 32'h5); tick();
    chk("mid_cescr", 32'(bus.ContEscr), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1; tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("mid_ocup20", 32'(bus.Ocupado), 32'h1);
    reset = 1'b1; tick();
    chk("mid_clect", 32'(bus.ContLect), 32'd0);
    chk("mid_cescr0", 32'(bus.ContEscr), 32'd0);
    reset = 1'b0;
    wait_clear(n_busy);
    chk("mid_clear_len", 32'(n_busy), 32'd64);
    drive(1'b1, 1'b0, 32'h4, 32'h0); tick();
    chk("mid_rd4", bus.DatoLeido, 32'h0);
    chk("mid_clect1", 32'(bus.ContLect), 32'd1);

    // ---- read counter saturation under continuous reads
    bad_valid = 0;
    for (int i = 0; i < 65533; i++) begin
      tick();
      if (bus.Valido !== 1'b1) bad_valid++;
    end
    chk("sat_fffe", 32'(bus.ContLect), 32'h0000FFFE);
    tick();
    if (bus.Valido !== 1'b1) bad_valid++;
    chk("sat_ffff", 32'(bus.ContLect), 32'h0000FFFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.Valido !== 1'b1) bad_valid++;
    end
    chk("sat_hold", 32'(bus.ContLect), 32'h0000FFFF);
    chk("sat_valid", 32'(bad_valid), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0); tick();
    chk("sat_idle_val", 32'(bus.Valido), 32'h0);
    chk("sat_cerr", 32'(bus.ContErr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_datos.md
MEM_DATOS -- requirements
Module: mem_datos

Interface
REQ-001 Parameter: PROF, default 64, word depth of the data memory (power of two, 4..1024).
REQ-002 Parameter: ANCHO, default 32, data word width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: LeerMem  input  1  read request from the control unit, sampled each rising edge.
REQ-006 Port: EscrMem  input  1  write request from the control unit, sampled each rising edge.
REQ-007 Port: Direccion  input  32  byte address from the ALU result.
REQ-008 Port: DatoEscr  input  ANCHO  write data from register file read port 2.
REQ-009 Port: DatoLeido  output  ANCHO  registered read data.
REQ-010 Port: Valido  output  1  one-cycle pulse; DatoLeido holds data for an accepted read.
REQ-011 Port: ErrorAcc  output  1  one-cycle pulse; the previous cycle's request was rejected.
REQ-012 Port: Ocupado  output  1  high while the post-reset clear sequence runs; requests are ignored.
REQ-013 Port: ContLect  output  16  count of accepted reads.
REQ-014 Port: ContEscr  output  16  count of accepted writes.
REQ-015 Port: ContErr  output  16  count of rejected requests.

Function
REQ-016 The FSM SHALL have two states: LIMPIAR and LISTO. Reset forces LIMPIAR with clear index 0.
REQ-017 In LIMPIAR, each rising edge with reset low SHALL write 0 to mem[index] and increment index.
REQ-018 On the edge that clears index PROF-1, the FSM SHALL move to LISTO. Ocupado SHALL be 0 from that edge on. Clear time is exactly PROF cycles after reset release.
REQ-019 In LIMPIAR, LeerMem and EscrMem SHALL be ignored. This means no access, no Valido, no ErrorAcc, and no counter change.
REQ-020 In LISTO, a request SHALL be rejected if any of the following holds:
- both LeerMem and EscrMem are 1;
- Direccion[1:0] != 0;
- Direccion >= 4*PROF.
REQ-021 A rejected request SHALL perform no memory access. ErrorAcc SHALL be 1 in the following cycle only. ContErr SHALL increment.
REQ-022 An accepted write at edge N SHALL store DatoEscr into mem[Direccion>>2] at edge N and increment ContEscr. Valido and DatoLeido SHALL be unaffected.
REQ-023 An accepted read at edge N SHALL place mem[Direccion>>2] on DatoLeido, with Valido=1, during cycle N+1 (latency 1). ContLect SHALL increment.
REQ-024 A read at edge N+1 of an address written at edge N SHALL return the newly written data.
REQ-025 Back-to-back accepted reads SHALL keep Valido high continuously, with DatoLeido updating every cycle.
REQ-026 DatoLeido SHALL hold its last value when no read is accepted. Valido SHALL be 0 in that case.
REQ-027 With neither request asserted in LISTO, memory and counters SHALL be unchanged.
REQ-028 Counters SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-029 Memory SHALL be a word array indexed by Direccion[log2(PROF)+1:2]. Upper address bits are used only for the range check.

Reset
REQ-030 While reset=1, the outputs SHALL be: DatoLeido=0, Valido=0, ErrorAcc=0, Ocupado=1, ContLect=0, ContEscr=0, ContErr=0.
REQ-031 Reset asserted mid-clear or mid-operation SHALL restart the clear sequence from index 0. Any request sampled in the same cycle SHALL be discarded.
REQ-032 After any reset, every memory word SHALL read as 0 once Ocupado falls.

Verification
REQ-033 Clear sequence: reset 1 cycle, then idle -> Ocupado=1 for exactly 64 cycles, then 0. Reads of addresses 0x00, 0x7C and 0xFC -> 0 with Valido.
REQ-034 Write then read: write 0xDEADBEEF to 0x10 at edge N, read 0x10 at edge N+1 -> DatoLeido=0xDEADBEEF with Valido=1 at cycle N+2. ContEscr=1, ContLect=1.
REQ-035 Rejections: each of the three requests below -> one ErrorAcc pulse each, ContErr=3, memory unchanged, Valido=0.
- read at 0x12;
- write at 0x100;
- LeerMem=EscrMem=1 at 0x0.
REQ-036 Busy ignore: write to 0x8 issued during LIMPIAR -> no ErrorAcc, ContEscr=0. After clear, read 0x8 -> 0.
REQ-037 Reset mid-operation: write 0x5 to 0x4, then assert reset at clear index 20 of the following clear -> Ocupado stays high 64 cycles after release, counters=0, read of 0x4 -> 0.
REQ-038 Saturation: force 65540 accepted reads -> ContLect=16'hFFFF. Valido pulses continue normally.
